// File: rtl/sram_responder_if.sv
// SLC-3 memory bus between the CPU Mem2IO path (master) and the SRAM responder (slave).
// OE/WE are active-low request strobes; R/ERR are one-cycle completion pulses.
interface sram_responder_if #(
  parameter int ADDR_W = 16
);
  logic              OE;
  logic              WE;
  logic [ADDR_W-1:0] ADDR;
  logic [15:0]       Data_to_SRAM;
  logic [15:0]       Data_from_SRAM;
  logic              R;
  logic              ERR;

  modport master (
    output OE, WE, ADDR, Data_to_SRAM,
    input  Data_from_SRAM, R, ERR
  );

  modport slave (
    input  OE, WE, ADDR, Data_to_SRAM,
    output Data_from_SRAM, R, ERR
  );
endinterface

// File: rtl/sram_responder.sv
// Word-addressed 16-bit memory responder: one access per request after WAIT_CYCLES wait states.
// Optional write protection below WPROT_LIMIT is enabled by defining SRAM_RESP_WPROT_EN.
module sram_responder #(
  parameter int          ADDR_W      = 16,
  parameter int          DEPTH       = 65536,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] WPROT_LIMIT = 16'h0010
) (
  input  logic            Clk,
  input  logic            Reset,
  sram_responder_if.slave bus
);
  // state   | meaning
  // S_IDLE  | waiting for OE=0 or WE=0; captures the request
  // S_WAIT  | counting down wait states; deasserted request aborts
  // S_DONE  | access finished; holds until OE and WE both release
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              op_write_q;
  logic              conflict_q;
  logic              r_q;
  logic              err_q;
  logic [15:0]       rdata_q;

  // 2-state storage so the array starts at zero without an initializer
  bit [15:0]         mem_q [DEPTH];

  logic             req_released;
  logic             in_range;
  logic             wprot_hit;
  logic             complete;
  logic             mem_we;
  logic [IDX_W-1:0] idx;

  assign req_released = bus.OE & bus.WE;
  assign in_range     = {1'b0, addr_q} < (ADDR_W+1)'(DEPTH);
  assign idx          = addr_q[IDX_W-1:0];
  assign complete     = (state_q == S_WAIT) && !req_released && (cnt_q == 4'd0);
  assign mem_we       = complete && op_write_q && in_range && !wprot_hit;

`ifdef SRAM_RESP_WPROT_EN
  assign wprot_hit = op_write_q && (addr_q < ADDR_W'(WPROT_LIMIT));
`else
  logic unused_wprot_limit;
  assign unused_wprot_limit = |WPROT_LIMIT;
  assign wprot_hit          = 1'b0;
`endif

  // Memory keeps its contents through reset; only the commit is gated by it.
  always_ff @(posedge Clk) begin
    if (Reset && mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= 16'h0000;
      op_write_q <= 1'b0;
      conflict_q <= 1'b0;
      r_q        <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 16'h0000;
    end else begin
      r_q   <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!bus.WE) begin
            addr_q     <= bus.ADDR;
            wdata_q    <= bus.Data_to_SRAM;
            op_write_q <= 1'b1;
            conflict_q <= !bus.OE;
            cnt_q      <= 4'(WAIT_CYCLES);
            state_q    <= S_WAIT;
          end else if (!bus.OE) begin
            addr_q     <= bus.ADDR;
            op_write_q <= 1'b0;
            conflict_q <= 1'b0;
            cnt_q      <= 4'(WAIT_CYCLES);
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (req_released) begin
            state_q <= S_IDLE;
          end else if (cnt_q == 4'd0) begin
            r_q   <= 1'b1;
            err_q <= conflict_q | !in_range | wprot_hit;
            if (!op_write_q) begin
              rdata_q <= in_range ? mem_q[idx] : 16'h0000;
            end
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          if (req_released) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.R              = r_q;
  assign bus.ERR            = err_q;
  assign bus.Data_from_SRAM = rdata_q;
endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder with DEPTH=256 and WAIT_CYCLES=2.
module tb_sram_responder;
  logic Clk;
  logic Reset;
  int   n_total;
  int   n_pass;

  sram_responder_if #(.ADDR_W(16)) bus ();

  sram_responder #(
    .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(2), .WPROT_LIMIT(16'h0010)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Drives one request, scrambles ADDR/data after capture, waits for R, releases in the R cycle.
  task automatic access(input logic wr, input logic rd, input logic [15:0] a,
                        input logic [15:0] d, output int lat, output logic err,
                        output logic [15:0] rdata);
    bus.WE = !wr;
    bus.OE = !rd;
    bus.ADDR = a;
    bus.Data_to_SRAM = d;
    lat = -1;
    err = 1'b0;
    rdata = 16'h0000;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      cyc();
      if (i == 1) begin
        bus.ADDR = ~a;
        bus.Data_to_SRAM = ~d;
      end
      if (bus.R) begin
        lat = i;
        err = bus.ERR;
        rdata = bus.Data_from_SRAM;
      end
    end
    bus.WE = 1'b1;
    bus.OE = 1'b1;
    cyc();
    check("r_one_cycle", 16'(bus.R), 16'h0000);
    check("err_one_cycle", 16'(bus.ERR), 16'h0000);
    cyc();
  endtask

  initial begin
    int          lat;
    logic        err;
    logic [15:0] rd;
    int          rcnt;
    int          first;

    n_total = 0;
    n_pass  = 0;
    Reset = 1'b0;
    bus.OE = 1'b1;
    bus.WE = 1'b1;
    bus.ADDR = 16'h0000;
    bus.Data_to_SRAM = 16'h0000;

    cyc();
    cyc();
    check("reset_r", 16'(bus.R), 16'h0000);
    check("reset_err", 16'(bus.ERR), 16'h0000);
    check("reset_rdata", bus.Data_from_SRAM, 16'h0000);
    Reset = 1'b1;
    cyc();

    access(1'b1, 1'b0, 16'h0020, 16'h1234, lat, err, rd);
    check("wr20_latency", 16'(lat), 16'd4);
    check("wr20_err", 16'(err), 16'h0000);
    access(1'b0, 1'b1, 16'h0020, 16'h0000, lat, err, rd);
    check("rd20_latency", 16'(lat), 16'd4);
    check("rd20_data", rd, 16'h1234);
    check("rd20_err", 16'(err), 16'h0000);

    // OE held low well past completion: exactly one pulse, three edges after capture
    bus.OE = 1'b0;
    bus.ADDR = 16'h0020;
    rcnt = 0;
    first = -1;
    for (int i = 1; i <= 14; i++) begin
      cyc();
      if (bus.R) begin
        rcnt++;
        if (first < 0) first = i;
      end
    end
    check("hold_pulse_count", 16'(rcnt), 16'd1);
    check("hold_first_r", 16'(first), 16'd4);
    bus.OE = 1'b1;
    cyc();
    cyc();

    // write aborted in its first wait cycle
    bus.WE = 1'b0;
    bus.ADDR = 16'h0030;
    bus.Data_to_SRAM = 16'hBEEF;
    cyc();
    bus.WE = 1'b1;
    rcnt = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (bus.R) rcnt++;
    end
    check("abort_no_r", 16'(rcnt), 16'd0);
    access(1'b0, 1'b1, 16'h0030, 16'h0000, lat, err, rd);
    check("abort_readback", rd, 16'h0000);

    access(1'b1, 1'b1, 16'h0040, 16'hA5A5, lat, err, rd);
    check("both_latency", 16'(lat), 16'd4);
    check("both_err", 16'(err), 16'h0001);
    access(1'b0, 1'b1, 16'h0040, 16'h0000, lat, err, rd);
    check("both_readback", rd, 16'hA5A5);
    check("both_readback_err", 16'(err), 16'h0000);

    access(1'b0, 1'b1, 16'h0100, 16'h0000, lat, err, rd);
    check("oor_rd_data", rd, 16'h0000);
    check("oor_rd_err", 16'(err), 16'h0001);
    access(1'b1, 1'b0, 16'h0100, 16'h9999, lat, err, rd);
    check("oor_wr_latency", 16'(lat), 16'd4);
    check("oor_wr_err", 16'(err), 16'h0001);
    access(1'b0, 1'b1, 16'h0000, 16'h0000, lat, err, rd);
    check("oor_wr_mem0", rd, 16'h0000);

    access(1'b1, 1'b0, 16'h0005, 16'h7777, lat, err, rd);
`ifdef SRAM_RESP_WPROT_EN
    check("wprot_wr_err", 16'(err), 16'h0001);
    access(1'b0, 1'b1, 16'h0005, 16'h0000, lat, err, rd);
    check("wprot_readback", rd, 16'h0000);
`else
    check("wprot_wr_err", 16'(err), 16'h0000);
    access(1'b0, 1'b1, 16'h0005, 16'h0000, lat, err, rd);
    check("wprot_readback", rd, 16'h7777);
`endif
    check("wprot_rd_err", 16'(err), 16'h0000);

    // reset while a write to 0x0050 is in WAIT
    bus.WE = 1'b0;
    bus.ADDR = 16'h0050;
    bus.Data_to_SRAM = 16'h4321;
    cyc();
    Reset = 1'b0;
    bus.WE = 1'b1;
    rcnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (bus.R) rcnt++;
    end
    check("rst_mid_no_r", 16'(rcnt), 16'd0);
    check("rst_mid_rdata", bus.Data_from_SRAM, 16'h0000);
    Reset = 1'b1;
    cyc();
    access(1'b0, 1'b1, 16'h0050, 16'h0000, lat, err, rd);
    check("rst_mid_mem50", rd, 16'h0000);
    access(1'b0, 1'b1, 16'h0020, 16'h0000, lat, err, rd);
    check("rst_retain_mem20", rd, 16'h1234);
    access(1'b0, 1'b1, 16'h0040, 16'h0000, lat, err, rd);
    check("rst_retain_mem40", rd, 16'hA5A5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the SLC-3 memory bus: the far end of the OE/WE/ADDR/Data_to_SRAM interface driven by the CPU's Mem2IO path. It holds a word-addressed 16-bit memory array and services one read or write per request after a configurable number of wait states. Completion is signalled with a one-cycle ready pulse, which the ISDU memory states poll. It replaces the external SRAM in simulation and in on-chip builds.

## Interface

- ADDR_W, 16, address width in bits
- DEPTH, 65536, number of 16-bit words; addresses ≥ DEPTH are out of range
- WAIT_CYCLES, 2, wait states between request capture and completion (0–15)
- WPROT_LIMIT, 16'h0010, first writable address; used only when SRAM_RESP_WPROT_EN is defined

- Clk  in  1  system clock; all activity is on the rising edge
- Reset  in  1  synchronous, active-low reset
- OE  in  1  active-low read request
- WE  in  1  active-low write request
- ADDR  in  ADDR_W  word address
- Data_to_SRAM  in  16  write data
- Data_from_SRAM  out  16  read data; holds the last completed read
- R  out  1  ready; one-cycle completion pulse
- ERR  out  1  error; one-cycle pulse coincident with R

## Operation

- States: IDLE, WAIT, DONE.
- IDLE:
  - If WE=0, capture ADDR and Data_to_SRAM, set op=write, load the counter with WAIT_CYCLES, and go to WAIT.
  - Else if OE=0, capture ADDR, set op=read, load the counter, and go to WAIT.
  - If WE=0 and OE=0 together, the request is a write and ERR is flagged at completion.
- WAIT:
  - If the request deasserts (OE=1 and WE=1), abort to IDLE. No write happens and R does not pulse.
  - Else if the counter is 0, complete the access: R=1, then go to DONE.
  - Else decrement the counter.
- Completion:
  - A read loads Data_from_SRAM from mem[captured addr].
  - A write updates mem[captured addr].
  - An out-of-range read returns 16'h0000 with ERR=1.
  - An out-of-range write is dropped with ERR=1.
- DONE: stay until OE=1 and WE=1, then go to IDLE. A held request never produces a second access.
- ADDR and data changes after capture are ignored.
- Reset (Reset=0 at an edge), including mid-operation:
  - State goes to IDLE and any in-flight write is discarded.
  - Outputs: R=0, ERR=0, Data_from_SRAM=16'h0000.
  - Memory contents are retained. The array is zero at time zero.

## Timing

- Request sampled at edge k in IDLE → R high for the cycle after edge k+1+WAIT_CYCLES. With WAIT_CYCLES=0, R is high after edge k+1.
- The write commit and the Data_from_SRAM update occur at the same edge that raises R.
- R and ERR are registered, last exactly one cycle, and do not depend combinationally on the inputs.
- Minimum request spacing is WAIT_CYCLES+3 cycles: capture, waits, completion, DONE release, IDLE.
- Back-to-back throughput is one access per WAIT_CYCLES+3 cycles, provided the initiator releases OE/WE in the R cycle.

## Configuration

- SRAM_RESP_WPROT_EN defined: writes to address < WPROT_LIMIT are dropped at completion. R pulses and ERR=1. Reads are unaffected.
- Not defined: WPROT_LIMIT is ignored and all in-range writes commit.

## Test plan

- Reset=0 for 2 cycles → R=0, ERR=0, Data_from_SRAM=16'h0000. Then write 16'h1234 to 16'h0020 and read it back: read data=16'h1234, ERR=0.
- WAIT_CYCLES=2: OE=0 sampled at edge 10 → R high only after edge 13. OE held low for 10 more cycles → exactly one R pulse.
- Write 16'hBEEF to 16'h0030, deassert WE at the first WAIT cycle, then read 16'h0030 → 16'h0000, and no R during the aborted write.
- OE=0 and WE=0 together with ADDR=16'h0040, data 16'hA5A5 → R and ERR pulse together. A later read of 16'h0040 returns 16'hA5A5.
- DEPTH=256: read 16'h0100 → 16'h0000 with ERR=1. Write 16'h0100 → ERR=1 and mem[16'h0000] is unchanged.
- With SRAM_RESP_WPROT_EN: write 16'h7777 to 16'h0005 → ERR=1 and a readback gives 16'h0000. Without the macro, the readback gives 16'h7777 and ERR=0.
- Assert Reset in the WAIT state of a write to 16'h0050 → no R pulse and memory unchanged; earlier-written data survives the reset.
